add_share_sched: RTL and testbench
==================================

ADD_SHARE_SCHED -- requirements
Module: add_share_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters sharing the adder (power of 2, 2..8).
REQ-002 SHALL have parameter W, default 16, meaning operand width; sum width W+1.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_a  input  NREQ*W  packed operand A; requester i at bits [i*W +: W].
REQ-008 SHALL have port req_b  input  NREQ*W  packed operand B, same packing.
REQ-009 SHALL have port add_a  output  W  registered operand A to the external shared adder.
REQ-010 SHALL have port add_b  output  W  registered operand B to the external shared adder.
REQ-011 SHALL have port add_o  input  W+1  combinational sum returned by the external adder.
REQ-012 SHALL have port rsp_valid  output  1  result valid.
REQ-013 SHALL have port rsp_ready  input  1  consumer accept.
REQ-014 SHALL have port rsp_sum  output  W+1  captured add_o.
REQ-015 SHALL have port rsp_id  output  $clog2(NREQ)  index of the requester owning rsp_sum.
REQ-016 SHALL have ports err_clr input 1, err_acc output 32, err_max output W+1 (error monitor, see Configuration).

Function
REQ-017 SHALL arbitrate round-robin: a priority pointer names the highest-priority requester; the grant goes to the first asserted req_valid at or after the pointer, modulo NREQ.
REQ-018 SHALL advance the pointer to (granted index + 1) mod NREQ only on a transfer (req_valid & req_ready); otherwise it holds.
REQ-019 SHALL use a two-stage pipeline: S1 holds add_a/add_b/id/valid; S2 holds rsp_sum/rsp_id/rsp_valid.
REQ-020 SHALL assert req_ready[g] for grant g only when S1 is empty or S1 advances this cycle; S1 advances when S2 is empty or rsp_ready is high.
REQ-021 SHALL produce rsp_valid two cycles after the accepting edge when unstalled; throughput one result per cycle.
REQ-022 SHALL hold rsp_sum/rsp_id stable while rsp_valid & !rsp_ready; no result is dropped or duplicated.
REQ-023 SHALL hold add_a/add_b stable while S1 is stalled, so that add_o remains valid.
REQ-024 SHALL treat the external adder as purely combinational; it SHALL perform no arithmetic on the result path itself.
REQ-025 SHALL return results in acceptance order.

Reset
REQ-026 SHALL, on rst, clear both stage valids, pointer=0, add_a=add_b=0, rsp_sum=0, rsp_id=0, err_acc=0, err_max=0; req_ready SHALL be 0 while rst is high.
REQ-027 SHALL discard in-flight operations on reset mid-operation; no rsp_valid appears for them after release.

Configuration
REQ-028 Macro ADD_SHARE_ERRMON_EN SHALL enable the error monitor: S1 also registers exact A+B; on each S2 capture, |add_o - exact| is added to err_acc (saturating at 2^32-1) and err_max is updated to the maximum; err_clr (synchronous) zeroes both, with a capture in the same cycle having priority over the clear.
REQ-029 Without ADD_SHARE_ERRMON_EN, the ports SHALL remain, err_acc/err_max SHALL be tied to 0, err_clr SHALL be ignored, and no exact adder SHALL be inferred.

Structure
REQ-030 A shared package SHALL hold the W/NREQ defaults, an ID width function, and the err_acc width constant (32).
REQ-031 The round-robin arbiter SHALL be one sub-module, rr_arb (inputs: req, pointer; outputs: one-hot grant, index).

Verification (exact-adder stub unless stated)
REQ-032 Req0 a=0x0001 b=0x0002 only -> rsp_valid two cycles after accept, rsp_sum=0x00003, rsp_id=0.
REQ-033 All 4 requesters hold valid continuously, pointer=0 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence is the same.
REQ-034 rsp_ready low for 5 cycles with a stream of requests -> S1 and S2 fill, req_ready goes to all 0, outputs stable, and all results arrive in order once released.
REQ-035 a=0xFFFF b=0xFFFF -> rsp_sum=0x1FFFE (carry-out in bit W).
REQ-036 rst pulsed while S1 and S2 are valid -> rsp_valid=0 immediately, no stale result afterward, next grant goes to req0.
REQ-037 With ADD_SHARE_ERRMON_EN and the approximate adder, apply a=0x00FF b=0x0001 and compare against the exact sum 0x00100 -> err_acc = |add_o - 0x100| and err_max is equal to it; err_clr then returns both to 0.

Source files
------------

// File: rtl/add_share_sched_pkg.sv
// Shared defaults and helpers for the shared-adder scheduler.
package add_share_sched_pkg;
    localparam int NREQ_DEF  = 4;
    localparam int W_DEF     = 16;
    localparam int ERR_ACC_W = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/add_share_sched_rr_arb.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping mod N.
module rr_arb
    import add_share_sched_pkg::*;
#(
    parameter int N = NREQ_DEF
) (
    input  logic [N-1:0]          req,
    input  logic [id_w(N)-1:0]    ptr,
    output logic [N-1:0]          gnt,
    output logic [id_w(N)-1:0]    idx
);
    localparam int IDW = id_w(N);

    logic [IDW-1:0] cand;
    logic           found;

    // N is a power of two, so IDW-bit addition wraps exactly mod N.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IDW'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/add_share_sched.sv
// Time-shares one external combinational adder among NREQ requesters via a 2-stage pipe.
// Define ADD_SHARE_ERRMON_EN to enable the approximate-adder error monitor.
module add_share_sched
    import add_share_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    output logic [W-1:0]             add_a,
    output logic [W-1:0]             add_b,
    input  logic [W:0]               add_o,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [W:0]               rsp_sum,
    output logic [id_w(NREQ)-1:0]    rsp_id,
    input  logic                     err_clr,
    output logic [ERR_ACC_W-1:0]     err_acc,
    output logic [W:0]               err_max
);
    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            s1_vld_q, s1_vld_d;
    logic [W-1:0]    add_a_q, add_a_d, add_b_q, add_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic [W:0]      rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic            s1_adv, s1_take, xfer;
    logic [W-1:0]    a_sel, b_sel;

    rr_arb #(.N(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign s1_adv    = !rsp_vld_q || rsp_ready;
    assign s1_take   = !s1_vld_q || s1_adv;
    assign req_ready = (rst || !s1_take) ? '0 : gnt;
    assign xfer      = |req_ready;
    assign a_sel     = req_a[gnt_idx*W +: W];
    assign b_sel     = req_b[gnt_idx*W +: W];

    always_comb begin
        ptr_d     = ptr_q;
        s1_vld_d  = s1_vld_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        s1_id_d   = s1_id_q;
        rsp_vld_d = rsp_vld_q;
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
        if (xfer)
            ptr_d = gnt_idx + IDW'(1);
        // Operands only change on a new accept so add_o stays valid while stalled.
        if (s1_take) begin
            s1_vld_d = xfer;
            if (xfer) begin
                add_a_d = a_sel;
                add_b_d = b_sel;
                s1_id_d = gnt_idx;
            end
        end
        if (s1_adv) begin
            rsp_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                rsp_sum_d = add_o;
                rsp_id_d  = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            s1_id_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            s1_vld_q  <= s1_vld_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            s1_id_q   <= s1_id_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_vld_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;

`ifdef ADD_SHARE_ERRMON_EN
    localparam int AW = ERR_ACC_W + 1;

    logic [W:0]           exact_q, exact_d;
    logic [ERR_ACC_W-1:0] acc_q, acc_d;
    logic [W:0]           max_q, max_d;
    logic [W:0]           diff;
    logic [AW-1:0]        acc_sum;
    logic                 cap;

    // A capture into S2 wins over a same-cycle clear.
    always_comb begin
        exact_d = exact_q;
        if (xfer)
            exact_d = {1'b0, a_sel} + {1'b0, b_sel};
        cap     = s1_adv && s1_vld_q;
        diff    = (add_o >= exact_q) ? (add_o - exact_q) : (exact_q - add_o);
        acc_sum = {1'b0, acc_q} + AW'(diff);
        acc_d   = acc_q;
        max_d   = max_q;
        if (cap) begin
            acc_d = acc_sum[ERR_ACC_W] ? '1 : acc_sum[ERR_ACC_W-1:0];
            if (diff > max_q)
                max_d = diff;
        end else if (err_clr) begin
            acc_d = '0;
            max_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exact_q <= '0;
            acc_q   <= '0;
            max_q   <= '0;
        end else begin
            exact_q <= exact_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
        end
    end

    assign err_acc = acc_q;
    assign err_max = max_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_acc        = '0;
    assign err_max        = '0;
`endif
endmodule

// File: tb/tb_add_share_sched.sv
// Randomized + directed bench for add_share_sched against an in-order queue model.
module tb_add_share_sched;
    localparam int NREQ = 4;
    localparam int W    = 16;

    logic            clk, rst;
    logic [NREQ-1:0] req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [W-1:0]    add_a, add_b;
    logic [W:0]      add_o;
    logic            rsp_valid, rsp_ready;
    logic [W:0]      rsp_sum;
    logic [1:0]      rsp_id;
    logic            err_clr;
    logic [31:0]     err_acc;
    logic [W:0]      err_max;

    add_share_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .err_clr(err_clr), .err_acc(err_acc), .err_max(err_max)
    );

    // External adder stub; the approximate variant forces the LSB high.
    function automatic logic [W:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ADD_SHARE_ERRMON_EN
        return ({1'b0, a} + {1'b0, b}) | 17'h1;
`else
        return {1'b0, a} + {1'b0, b};
`endif
    endfunction

    assign add_o = f_add(add_a, add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] sum;
        int         id;
        int         acc_edge;
    } item_t;

    item_t q[$];
    int    m_ptr;
    int    edge_cnt;
    int    checks;
    int    failures;
    bit    pend_acc, pend_ret;
    item_t pend_item;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Model: at most two in flight; the oldest item is visible one edge after acceptance.
    task automatic settle_check();
        int pick;
        bit can, exp_v;
        logic [NREQ-1:0] exp_rdy;
        #1;
        pick    = rr_pick(req_valid, m_ptr);
        can     = (q.size() < 2) || rsp_ready;
        exp_rdy = '0;
        if (pick >= 0 && can) exp_rdy[pick] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        exp_v = (q.size() > 0) && (q[0].acc_edge < edge_cnt);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            chk("rsp_sum", rsp_sum, q[0].sum);
            chk("rsp_id", rsp_id, q[0].id);
        end
`ifndef ADD_SHARE_ERRMON_EN
        chk("err_acc_tied", err_acc, 0);
        chk("err_max_tied", err_max, 0);
`endif
        pend_acc = (exp_rdy != 0);
        pend_ret = exp_v && rsp_ready;
        if (pend_acc) begin
            pend_item.sum = f_add(req_a[pick*W +: W], req_b[pick*W +: W]);
            pend_item.id  = pick;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        edge_cnt++;
        if (pend_ret) void'(q.pop_front());
        if (pend_acc) begin
            pend_item.acc_edge = edge_cnt;
            q.push_back(pend_item);
            m_ptr = (pend_item.id + 1) % NREQ;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_err_acc", err_acc, 0);
        chk("rst_err_max", err_max, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        q.delete();
        m_ptr = 0;
    endtask

    initial begin
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};
        checks = 0; failures = 0; edge_cnt = 0; m_ptr = 0;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1; err_clr = 1'b0;

        do_reset();

        // Single request on requester 0.
        req_a[0 +: W] = 16'h0001; req_b[0 +: W] = 16'h0002; req_valid = 4'b0001;
        settle_check();
        chk("t032_accept", req_ready, 4'b0001);
        advance();
        req_valid = '0;
        step();
        settle_check();
        chk("t032_valid", rsp_valid, 1);
        chk("t032_sum", rsp_sum, f_add(16'h0001, 16'h0002));
        chk("t032_sum_lit", rsp_sum[W:1], 16'h0001);
        chk("t032_id", rsp_id, 0);
        advance();
        repeat (2) step();

        // All requesters continuously valid from pointer 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 16'h0100 * (i + 1);
            req_b[i*W +: W] = 16'(i);
        end
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 5) ? 4'hF : 4'h0;
            settle_check();
            if (k < 5) chk("t033_grant", req_ready, 4'b0001 << exp_seq[k]);
            if (k >= 2) begin
                chk("t033_rsp_valid", rsp_valid, 1);
                chk("t033_rsp_id", rsp_id, exp_seq[k-2]);
            end
            advance();
        end
        repeat (2) step();

        // Backpressure: fill both stages, stall 5 cycles, then drain in order.
        req_valid = 4'hF;
        repeat (3) step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle_check();
            chk("t034_stall_ready", req_ready, 0);
            chk("t034_stall_valid", rsp_valid, 1);
            advance();
        end
        rsp_ready = 1'b1;
        req_valid = 4'h0;
        repeat (5) step();

        // Carry-out into bit W.
        req_a[2*W +: W] = 16'hFFFF; req_b[2*W +: W] = 16'hFFFF; req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        settle_check();
        chk("t035_sum", rsp_sum, f_add(16'hFFFF, 16'hFFFF));
        chk("t035_carry", rsp_sum[W], 1);
        chk("t035_id", rsp_id, 2);
        advance();
        repeat (2) step();

        // Reset while both stages hold data; pointer is away from 0 beforehand.
        req_valid = 4'b0110;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("t036_rsp_valid_now", rsp_valid, 0);
        chk("t036_ready_in_rst", req_ready, 0);
        q.delete();
        m_ptr = 0;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'hF;
        settle_check();
        chk("t036_grant_req0", req_ready, 4'b0001);
        advance();
        req_valid = '0;
        repeat (4) step();

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 9) < 7);
            err_clr   = ($urandom_range(0, 7) == 0);
            step();
        end
        req_valid = '0; rsp_ready = 1'b1; err_clr = 1'b0;
        repeat (4) step();

`ifdef ADD_SHARE_ERRMON_EN
        // Approximate adder yields 0x101 against exact 0x100.
        do_reset();
        req_a[0 +: W] = 16'h00FF; req_b[0 +: W] = 16'h0001; req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        settle_check();
        chk("t037_sum", rsp_sum, 17'h00101);
        chk("t037_err_acc", err_acc, 1);
        chk("t037_err_max", err_max, 1);
        advance();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("t037_clr_acc", err_acc, 0);
        chk("t037_clr_max", err_max, 0);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
